// File: rtl/ahb_iopmp_mp_if.sv
// Bus bundle for the multi-channel AHB I/O PMP: config slave port plus the
// per-channel upstream (s_*) and downstream (m_*) AHB signals.
interface ahb_iopmp_mp_if #(
    parameter int NUM_PORTS  = 2,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                                  hsel;
    logic [ADDR_WIDTH-1:0]                 haddr;
    logic [3:0]                            hprot;
    logic [2:0]                            hsize;
    logic [1:0]                            htrans;
    logic [2:0]                            hburst;
    logic                                  hwrite;
    logic [DATA_WIDTH-1:0]                 hwdata;
    logic                                  hresp;
    logic                                  hready;
    logic [DATA_WIDTH-1:0]                 hrdata;

    logic [NUM_PORTS-1:0][ADDR_WIDTH-1:0]  s_haddr;
    logic [NUM_PORTS-1:0][3:0]             s_hprot;
    logic [NUM_PORTS-1:0][2:0]             s_hsize;
    logic [NUM_PORTS-1:0][1:0]             s_htrans;
    logic [NUM_PORTS-1:0][2:0]             s_hburst;
    logic [NUM_PORTS-1:0]                  s_hwrite;
    logic [NUM_PORTS-1:0][DATA_WIDTH-1:0]  s_hwdata;
    logic [NUM_PORTS-1:0]                  s_hresp;
    logic [NUM_PORTS-1:0]                  s_hgrant;
    logic [NUM_PORTS-1:0]                  s_hready;
    logic [NUM_PORTS-1:0][DATA_WIDTH-1:0]  s_hrdata;

    logic [NUM_PORTS-1:0]                  m_hsel;
    logic [NUM_PORTS-1:0][ADDR_WIDTH-1:0]  m_haddr;
    logic [NUM_PORTS-1:0][3:0]             m_hprot;
    logic [NUM_PORTS-1:0][2:0]             m_hsize;
    logic [NUM_PORTS-1:0][1:0]             m_htrans;
    logic [NUM_PORTS-1:0][2:0]             m_hburst;
    logic [NUM_PORTS-1:0]                  m_hwrite;
    logic [NUM_PORTS-1:0][DATA_WIDTH-1:0]  m_hwdata;
    logic [NUM_PORTS-1:0]                  m_hresp;
    logic [NUM_PORTS-1:0]                  m_hgrant;
    logic [NUM_PORTS-1:0]                  m_hready;
    logic [NUM_PORTS-1:0][DATA_WIDTH-1:0]  m_hrdata;

    modport slave (
        input  hsel, haddr, hprot, hsize, htrans, hburst, hwrite, hwdata,
        output hresp, hready, hrdata,
        input  s_haddr, s_hprot, s_hsize, s_htrans, s_hburst, s_hwrite, s_hwdata,
        output s_hresp, s_hgrant, s_hready, s_hrdata,
        output m_hsel, m_haddr, m_hprot, m_hsize, m_htrans, m_hburst, m_hwrite, m_hwdata,
        input  m_hresp, m_hgrant, m_hready, m_hrdata
    );

    modport master (
        output hsel, haddr, hprot, hsize, htrans, hburst, hwrite, hwdata,
        input  hresp, hready, hrdata,
        output s_haddr, s_hprot, s_hsize, s_htrans, s_hburst, s_hwrite, s_hwdata,
        input  s_hresp, s_hgrant, s_hready, s_hrdata,
        input  m_hsel, m_haddr, m_hprot, m_hsize, m_htrans, m_hburst, m_hwrite, m_hwdata,
        output m_hresp, m_hgrant, m_hready, m_hrdata
    );
endinterface

// File: rtl/ahb_iopmp_mp.sv
// Multi-channel AHB I/O PMP: per-channel base/mask region check, 2-cycle ERROR on deny,
// fault logging, and an AHB-lite config slave.
//   state   | meaning
//   PASS    | responses forwarded from downstream
//   ERR1    | first ERROR cycle, hready low, downstream held IDLE
//   ERR2    | second ERROR cycle, hready high, next transfer checked normally
module ahb_iopmp_mp #(
    parameter int NUM_PORTS   = 2,
    parameter int NUM_REGIONS = 8,
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32
) (
    input logic          hclk,
    input logic          hresetn,
    ahb_iopmp_mp_if.slave bus
);
    localparam int NT = NUM_PORTS * NUM_REGIONS;
    localparam logic [1:0] HTRANS_IDLE = 2'b00;

    typedef enum logic [1:0] {ST_PASS, ST_ERR1, ST_ERR2} state_e;

    logic [NUM_PORTS-1:0][NUM_REGIONS-1:0] en_q;
    logic [NUM_PORTS-1:0]                  lock_q, err_q, err_wr_q;
    logic [NUM_PORTS-1:0][7:0]             cnt_q, hitm_q;
    logic [NUM_PORTS-1:0][ADDR_WIDTH-1:0]  dump_q;
    logic [NT-1:0][ADDR_WIDTH-1:0]         base_q, mask_q;
    logic [NT-1:0][1:0]                    perm_q;
    logic                                  wr_pend_q;
    logic [11:0]                           wr_addr_q;
    logic [DATA_WIDTH-1:0]                 hrdata_q;

    logic [NUM_PORTS-1:0]                  fault_w, pass_w, stat_clr;
    logic [NUM_PORTS-1:0][NUM_REGIONS-1:0] hit_w;
    logic [DATA_WIDTH-1:0]                 rdata;
    logic [11:0]                           ra;
    logic [7:0]                            ridx, widx;
    logic                                  rd_en, wr_en;
    logic                                  unused_cfg;

    assign ra    = bus.haddr[11:0];
    assign ridx  = ra[11:4] - 8'h10;
    assign widx  = wr_addr_q[11:4] - 8'h10;
    assign rd_en = bus.hsel && !bus.hwrite && bus.htrans[1];
    assign wr_en = bus.hsel &&  bus.hwrite && bus.htrans[1];

    assign bus.hready = 1'b1;
    assign bus.hresp  = 1'b0;
    assign bus.hrdata = hrdata_q;
    assign unused_cfg = ^{bus.haddr[ADDR_WIDTH-1:12], bus.hprot, bus.hsize, bus.hburst};

    always_comb begin
        rdata = '0;
        if (ra[11:8] == 4'h0) begin
            for (int c = 0; c < NUM_PORTS; c++) begin
                if (ra[7:4] == 4'(c)) begin
                    case (ra[3:0])
                        4'h0:    rdata = {lock_q[c], 15'b0, 16'(en_q[c])};
                        4'h4:    rdata = {8'b0, hitm_q[c], cnt_q[c], 6'b0, err_wr_q[c], err_q[c]};
                        4'h8:    rdata = DATA_WIDTH'(dump_q[c]);
                        default: rdata = '0;
                    endcase
                end
            end
        end else begin
            for (int i = 0; i < NT; i++) begin
                if (ridx == 8'(i)) begin
                    case (ra[3:0])
                        4'h0:    rdata = DATA_WIDTH'(base_q[i]);
                        4'h4:    rdata = DATA_WIDTH'(mask_q[i]);
                        4'h8:    rdata = {30'b0, perm_q[i]};
                        default: rdata = '0;
                    endcase
                end
            end
        end
    end

    always_comb begin
        stat_clr = '0;
        for (int c = 0; c < NUM_PORTS; c++)
            stat_clr[c] = wr_pend_q && (wr_addr_q == 12'(c * 16 + 4)) && bus.hwdata[0];
    end

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            en_q      <= '0;
            lock_q    <= '0;
            err_q     <= '0;
            err_wr_q  <= '0;
            cnt_q     <= '0;
            hitm_q    <= '0;
            dump_q    <= '0;
            base_q    <= '0;
            mask_q    <= '0;
            perm_q    <= '0;
            wr_pend_q <= 1'b0;
            wr_addr_q <= '0;
            hrdata_q  <= '0;
        end else begin
            if (rd_en)
                hrdata_q <= rdata;
            wr_pend_q <= wr_en;
            if (wr_en)
                wr_addr_q <= ra;
            for (int c = 0; c < NUM_PORTS; c++) begin
                if (wr_pend_q && wr_addr_q == 12'(c * 16) && !lock_q[c]) begin
                    en_q[c]   <= bus.hwdata[NUM_REGIONS-1:0];
                    lock_q[c] <= bus.hwdata[31];
                end
                // A fault coinciding with the W1C counts as the first fault of a fresh log.
                if (fault_w[c]) begin
                    if (cnt_q[c] != 8'hFF)
                        cnt_q[c] <= cnt_q[c] + 8'd1;
                    if (!err_q[c] || stat_clr[c]) begin
                        err_q[c]    <= 1'b1;
                        err_wr_q[c] <= bus.s_hwrite[c];
                        dump_q[c]   <= bus.s_haddr[c];
                    end
                end else if (stat_clr[c]) begin
                    err_q[c] <= 1'b0;
                end
                if (pass_w[c])
                    hitm_q[c] <= 8'(hit_w[c]);
                for (int r = 0; r < NUM_REGIONS; r++) begin
                    if (wr_pend_q && wr_addr_q[11:8] != 4'h0 && widx == 8'(c * NUM_REGIONS + r)
                        && !lock_q[c]) begin
                        case (wr_addr_q[3:0])
                            4'h0:    base_q[c*NUM_REGIONS+r] <= ADDR_WIDTH'(bus.hwdata);
                            4'h4:    mask_q[c*NUM_REGIONS+r] <= ADDR_WIDTH'(bus.hwdata);
                            4'h8:    perm_q[c*NUM_REGIONS+r] <= bus.hwdata[1:0];
                            default: ;
                        endcase
                    end
                end
            end
        end
    end

    assign bus.m_hsel   = '1;
    assign bus.m_haddr  = bus.s_haddr;
    assign bus.m_hprot  = bus.s_hprot;
    assign bus.m_hsize  = bus.s_hsize;
    assign bus.m_hburst = bus.s_hburst;
    assign bus.m_hwrite = bus.s_hwrite;
    assign bus.m_hwdata = bus.s_hwdata;
    assign bus.s_hgrant = bus.m_hgrant;

    for (genvar c = 0; c < NUM_PORTS; c++) begin : g_ch
        state_e                 state_q, state_d;
        logic [NUM_REGIONS-1:0] hit;
        logic                   allowed;
        logic                   s_hresp_c, s_hready_c, fault_c, pass_c;
        logic [DATA_WIDTH-1:0]  s_hrdata_c;
        logic [1:0]             m_htrans_c;

        always_comb begin
            hit = '0;
            for (int r = 0; r < NUM_REGIONS; r++)
                hit[r] = en_q[c][r]
                    && ((bus.s_haddr[c] & mask_q[c*NUM_REGIONS+r]) == base_q[c*NUM_REGIONS+r])
                    && (bus.s_hwrite[c] ? perm_q[c*NUM_REGIONS+r][1] : perm_q[c*NUM_REGIONS+r][0]);
        end
        assign allowed = |hit;

        always_ff @(posedge hclk or negedge hresetn) begin
            if (!hresetn)
                state_q <= ST_PASS;
            else
                state_q <= state_d;
        end

        always_comb begin
            state_d = state_q;
            case (state_q)
                ST_PASS: if (fault_c) state_d = ST_ERR1;
                ST_ERR1: state_d = ST_ERR2;
                ST_ERR2: state_d = fault_c ? ST_ERR1 : ST_PASS;
                default: state_d = ST_PASS;
            endcase
        end

        always_comb begin
            s_hresp_c  = bus.m_hresp[c];
            s_hready_c = bus.m_hready[c];
            s_hrdata_c = bus.m_hrdata[c];
            case (state_q)
                ST_ERR1: begin
                    s_hresp_c  = 1'b1;
                    s_hready_c = 1'b0;
                    s_hrdata_c = '0;
                end
                ST_ERR2: begin
                    s_hresp_c  = 1'b1;
                    s_hready_c = 1'b1;
                    s_hrdata_c = '0;
                end
                default: ;
            endcase
            m_htrans_c = (allowed && state_q != ST_ERR1) ? bus.s_htrans[c] : HTRANS_IDLE;
            fault_c    = bus.s_htrans[c][1] && s_hready_c && !allowed && state_q != ST_ERR1;
            pass_c     = bus.s_htrans[c][1] && s_hready_c &&  allowed && state_q != ST_ERR1;
        end

        assign bus.s_hresp[c]  = s_hresp_c;
        assign bus.s_hready[c] = s_hready_c;
        assign bus.s_hrdata[c] = s_hrdata_c;
        assign bus.m_htrans[c] = m_htrans_c;
        assign fault_w[c]      = fault_c;
        assign pass_w[c]       = pass_c;
        assign hit_w[c]        = hit;
    end
endmodule

// File: tb/tb_ahb_iopmp_mp.sv
// Directed bench for ahb_iopmp_mp: deny/allow, ERROR sequencing, fault log, lock, W1C race, reset.
module tb_ahb_iopmp_mp;
    localparam int NP = 2;
    localparam int NR = 8;

    logic hclk = 1'b0;
    logic hresetn = 1'b0;
    int   n_chk = 0;
    int   n_err = 0;

    always #5 hclk = ~hclk;

    ahb_iopmp_mp_if #(.NUM_PORTS(NP), .ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

    ahb_iopmp_mp #(.NUM_PORTS(NP), .NUM_REGIONS(NR), .ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .hclk    (hclk),
        .hresetn (hresetn),
        .bus     (bus)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge hclk);
        #1;
    endtask

    task automatic cfg_wr(input logic [11:0] a, input logic [31:0] d);
        tick();
        bus.hsel = 1'b1; bus.hwrite = 1'b1; bus.htrans = 2'b10; bus.haddr = {20'h0, a};
        tick();
        bus.hsel = 1'b0; bus.hwrite = 1'b0; bus.htrans = 2'b00; bus.hwdata = d;
        tick();
    endtask

    task automatic rd_chk(input string tag, input logic [11:0] a, input logic [31:0] exp);
        tick();
        bus.hsel = 1'b1; bus.hwrite = 1'b0; bus.htrans = 2'b10; bus.haddr = {20'h0, a};
        tick();
        bus.hsel = 1'b0; bus.htrans = 2'b00;
        chk(tag, bus.hrdata, exp);
    endtask

    task automatic ch_drv(input int c, input logic [1:0] tr, input logic [31:0] a, input logic w);
        bus.s_htrans[c] = tr;
        bus.s_haddr[c]  = a;
        bus.s_hwrite[c] = w;
    endtask

    task automatic chk_rsp(input string tag, input int c, input logic resp, input logic rdy);
        @(negedge hclk);
        chk({tag, "_hresp"}, 32'(bus.s_hresp[c]), 32'(resp));
        chk({tag, "_hready"}, 32'(bus.s_hready[c]), 32'(rdy));
    endtask

    initial begin
        bus.hsel = 0; bus.haddr = '0; bus.hprot = '0; bus.hsize = 3'd2; bus.htrans = '0;
        bus.hburst = '0; bus.hwrite = 0; bus.hwdata = '0;
        bus.s_haddr = '0; bus.s_hprot = '0; bus.s_hsize = '0; bus.s_htrans = '0;
        bus.s_hburst = '0; bus.s_hwrite = '0; bus.s_hwdata = '0;
        bus.m_hresp = '0; bus.m_hgrant = '1; bus.m_hready = '1;
        bus.m_hrdata[0] = 32'hA5A5_0000;
        bus.m_hrdata[1] = 32'h5A5A_1111;
        repeat (2) @(posedge hclk);
        #1 hresetn = 1'b1;

        // reset state
        @(negedge hclk);
        chk("rst_hrdata", bus.hrdata, 32'h0);
        chk("rst_hready", 32'(bus.hready), 32'h1);
        chk("rst_s0_hresp", 32'(bus.s_hresp[0]), 32'h0);
        chk("rst_s0_hgrant", 32'(bus.s_hgrant[0]), 32'h1);

        // T1 default deny
        tick();
        ch_drv(0, 2'b10, 32'h2000_0000, 1'b0);
        @(negedge hclk);
        chk("t1_m0_htrans", 32'(bus.m_htrans[0]), 32'h0);
        chk("t1_s0_hready", 32'(bus.s_hready[0]), 32'h1);
        tick();
        ch_drv(0, 2'b00, 32'h0, 1'b0);
        chk_rsp("t1_err1", 0, 1'b1, 1'b0);
        chk("t1_err1_hrdata", bus.s_hrdata[0], 32'h0);
        tick();
        chk_rsp("t1_err2", 0, 1'b1, 1'b1);
        tick();
        chk_rsp("t1_pass", 0, 1'b0, 1'b1);
        rd_chk("t1_stat0", 12'h004, 32'h0000_0101);
        rd_chk("t1_dump0", 12'h008, 32'h2000_0000);

        // T2 one read-only region
        cfg_wr(12'h004, 32'h1);
        cfg_wr(12'h100, 32'h2000_0000);
        cfg_wr(12'h104, 32'hFFFF_0000);
        cfg_wr(12'h108, 32'h1);
        cfg_wr(12'h000, 32'h1);
        tick();
        ch_drv(0, 2'b10, 32'h2000_0040, 1'b0);
        @(negedge hclk);
        chk("t2_rd_m_htrans", 32'(bus.m_htrans[0]), 32'h2);
        chk("t2_rd_hrdata", bus.s_hrdata[0], 32'hA5A5_0000);
        tick();
        ch_drv(0, 2'b00, 32'h0, 1'b0);
        rd_chk("t2_stat0_hit", 12'h004, 32'h0001_0100);
        tick();
        ch_drv(0, 2'b10, 32'h2000_0040, 1'b1);
        @(negedge hclk);
        chk("t2_wr_m_htrans", 32'(bus.m_htrans[0]), 32'h0);
        tick();
        ch_drv(0, 2'b00, 32'h0, 1'b0);
        chk_rsp("t2_err1", 0, 1'b1, 1'b0);
        tick();
        tick();
        rd_chk("t2_stat0_wr", 12'h004, 32'h0001_0203);
        rd_chk("t2_dump0", 12'h008, 32'h2000_0040);

        // T3 denied burst on ch1, then saturation
        tick();
        ch_drv(1, 2'b10, 32'h3000_0000, 1'b0);
        for (int k = 0; k < 4; k++) begin
            tick();
            if (k < 3) ch_drv(1, 2'b11, 32'h3000_0000 + 32'(4 * (k + 1)), 1'b0);
            else       ch_drv(1, 2'b00, 32'h0, 1'b0);
            chk_rsp($sformatf("t3_b%0d_err1", k), 1, 1'b1, 1'b0);
            tick();
            chk_rsp($sformatf("t3_b%0d_err2", k), 1, 1'b1, 1'b1);
        end
        tick();
        rd_chk("t3_stat1", 12'h014, 32'h0000_0401);
        rd_chk("t3_dump1", 12'h018, 32'h3000_0000);
        tick();
        ch_drv(1, 2'b10, 32'h3000_1000, 1'b0);
        repeat (600) @(posedge hclk);
        #1 ch_drv(1, 2'b00, 32'h0, 1'b0);
        tick();
        rd_chk("t3_stat1_sat", 12'h014, 32'h0000_FF01);
        rd_chk("t3_dump1_hold", 12'h018, 32'h3000_0000);

        // T4 lock
        cfg_wr(12'h000, 32'h8000_0003);
        rd_chk("t4_ctrl0", 12'h000, 32'h8000_0003);
        cfg_wr(12'h000, 32'h0);
        cfg_wr(12'h100, 32'h1234_0000);
        cfg_wr(12'h108, 32'h3);
        rd_chk("t4_ctrl0_locked", 12'h000, 32'h8000_0003);
        rd_chk("t4_base0_locked", 12'h100, 32'h2000_0000);
        rd_chk("t4_perm0_locked", 12'h108, 32'h1);
        cfg_wr(12'h180, 32'h7000_0000);
        rd_chk("t4_ch1_base_open", 12'h180, 32'h7000_0000);
        cfg_wr(12'h004, 32'h1);
        rd_chk("t4_stat0_clr", 12'h004, 32'h0001_0202);
        rd_chk("t4_unmapped_ch", 12'h0F0, 32'h0);
        rd_chk("t4_unmapped_off", 12'h00C, 32'h0);

        // T5 W1C racing a new fault
        tick();
        bus.hsel = 1'b1; bus.hwrite = 1'b1; bus.htrans = 2'b10; bus.haddr = 32'h014;
        tick();
        bus.hsel = 1'b0; bus.hwrite = 1'b0; bus.htrans = 2'b00; bus.hwdata = 32'h1;
        ch_drv(1, 2'b10, 32'h4000_0000, 1'b1);
        tick();
        ch_drv(1, 2'b00, 32'h0, 1'b0);
        tick();
        tick();
        rd_chk("t5_stat1", 12'h014, 32'h0000_FF03);
        rd_chk("t5_dump1", 12'h018, 32'h4000_0000);

        // T6 reset during ERR1
        tick();
        ch_drv(0, 2'b10, 32'h5000_0000, 1'b0);
        tick();
        ch_drv(0, 2'b00, 32'h0, 1'b0);
        chk_rsp("t6_err1", 0, 1'b1, 1'b0);
        #1 hresetn = 1'b0;
        #1;
        chk("t6_rst_hresp", 32'(bus.s_hresp[0]), 32'h0);
        chk("t6_rst_hready", 32'(bus.s_hready[0]), 32'h1);
        tick();
        chk("t6_edge_hresp", 32'(bus.s_hresp[0]), 32'h0);
        hresetn = 1'b1;
        rd_chk("t6_ctrl0", 12'h000, 32'h0);
        rd_chk("t6_stat0", 12'h004, 32'h0);
        rd_chk("t6_dump0", 12'h008, 32'h0);
        rd_chk("t6_base0", 12'h100, 32'h0);
        rd_chk("t6_stat1", 12'h014, 32'h0);
        rd_chk("t6_base8", 12'h180, 32'h0);
        tick();
        ch_drv(0, 2'b10, 32'h2000_0040, 1'b0);
        @(negedge hclk);
        chk("t6_deny_m_htrans", 32'(bus.m_htrans[0]), 32'h0);
        tick();
        ch_drv(0, 2'b00, 32'h0, 1'b0);
        tick();
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
